// File: rtl/hdu_fwd.sv
// Hazard detection and EX-operand forwarding for the 5-stage RV32I pipeline.
// Adds a data-memory wait FSM with optional timeout and saturating stall/flush counters.
module hdu_fwd #(
   parameter int FWD_EN      = 1,
   parameter int RF_WT       = 1,
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [31:0]      i_instr_id,
   input  logic [31:0]      i_instr_ex,
   input  logic [31:0]      i_instr_mem,
   input  logic [31:0]      i_instr_wb,
   input  logic             i_rd_wren_ex,
   input  logic             i_rd_wren_mem,
   input  logic             i_rd_wren_wb,
   input  logic             i_mem_rden_ex,
   input  logic             i_pc_sel_ex,
   input  logic             i_mem_req,
   input  logic             i_mem_ack,
   output logic             o_en_pc,
   output logic             o_en_if,
   output logic             o_en_id,
   output logic             o_en_ex,
   output logic             o_en_mem,
   output logic             o_flush_if,
   output logic             o_flush_id,
   output logic [1:0]       o_fwd_a,
   output logic [1:0]       o_fwd_b,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt,
   output logic             o_mem_timeout
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W:0] TMO = (WAIT_W + 1)'(MEM_TIMEOUT);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;

   typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_TOUT} state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W:0]   wait_inc;

   function automatic logic uses_rs1(input logic [6:0] op);
      return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_R || op == OP_S || op == OP_B);
   endfunction

   // x0 is never a producer, and an unused source field never matches.
   function automatic logic hit(input logic wren, input logic [4:0] rd,
                                input logic used, input logic [4:0] rs);
      return wren && (rd != 5'd0) && used && (rd == rs);
   endfunction

   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, rd_ex, rd_mem, rd_wb;
   logic       id_use1, id_use2, ex_use1, ex_use2;
   logic       id_hit_ex, id_hit_mem, id_hit_wb;
   logic       data_haz, freeze;
   logic       unused_bits;

   assign id_rs1  = i_instr_id[19:15];
   assign id_rs2  = i_instr_id[24:20];
   assign ex_rs1  = i_instr_ex[19:15];
   assign ex_rs2  = i_instr_ex[24:20];
   assign rd_ex   = i_instr_ex[11:7];
   assign rd_mem  = i_instr_mem[11:7];
   assign rd_wb   = i_instr_wb[11:7];
   assign id_use1 = uses_rs1(i_instr_id[6:0]);
   assign id_use2 = uses_rs2(i_instr_id[6:0]);
   assign ex_use1 = uses_rs1(i_instr_ex[6:0]);
   assign ex_use2 = uses_rs2(i_instr_ex[6:0]);

   assign unused_bits = ^{i_instr_id[31:25], i_instr_id[14:7], i_instr_ex[31:25],
                          i_instr_ex[14:12], i_instr_mem[31:12], i_instr_mem[6:0],
                          i_instr_wb[31:12], i_instr_wb[6:0]};

   assign id_hit_ex  = hit(i_rd_wren_ex, rd_ex, id_use1, id_rs1) |
                       hit(i_rd_wren_ex, rd_ex, id_use2, id_rs2);
   assign id_hit_mem = hit(i_rd_wren_mem, rd_mem, id_use1, id_rs1) |
                       hit(i_rd_wren_mem, rd_mem, id_use2, id_rs2);
   assign id_hit_wb  = hit(i_rd_wren_wb, rd_wb, id_use1, id_rs1) |
                       hit(i_rd_wren_wb, rd_wb, id_use2, id_rs2);

   // With forwarding only a load in EX is too late; without it every in-flight producer is.
   assign data_haz = (FWD_EN != 0) ?
                     ((i_mem_rden_ex && id_hit_ex) || (RF_WT == 0 && id_hit_wb)) :
                     (id_hit_ex || id_hit_mem || (RF_WT == 0 && id_hit_wb));

   assign freeze = ((state == ST_RUN)  && i_mem_req && !i_mem_ack) ||
                   ((state == ST_WAIT) && !i_mem_ack) ||
                    (state == ST_TOUT);

   assign wait_inc = {1'b0, wait_cnt} + 1'b1;

   // A branch held in EX during a freeze keeps i_pc_sel_ex high, so its flush lands
   // on the first unfrozen cycle without extra state.
   always_comb begin
      // NOTE: every output gets a default first, so no path through this block infers a latch.
      o_en_pc    = 1'b1;
      o_en_if    = 1'b1;
      o_en_id    = 1'b1;
      o_en_ex    = 1'b1;
      o_en_mem   = 1'b1;
      o_flush_if = 1'b0;
      o_flush_id = 1'b0;
      if (!i_reset) begin
         if (freeze) begin
            o_en_pc  = 1'b0;
            o_en_if  = 1'b0;
            o_en_id  = 1'b0;
            o_en_ex  = 1'b0;
            o_en_mem = 1'b0;
         end else if (i_pc_sel_ex) begin
            o_flush_if = 1'b1;
            o_flush_id = 1'b1;
         end else if (data_haz) begin
            o_en_pc    = 1'b0;
            o_en_if    = 1'b0;
            o_flush_id = 1'b1;
         end
      end
   end

   always_comb begin
      o_fwd_a = 2'b00;
      o_fwd_b = 2'b00;
      if (FWD_EN != 0 && !i_reset) begin
         if (hit(i_rd_wren_mem, rd_mem, ex_use1, ex_rs1))     o_fwd_a = 2'b01;
         else if (hit(i_rd_wren_wb, rd_wb, ex_use1, ex_rs1))  o_fwd_a = 2'b10;
         if (hit(i_rd_wren_mem, rd_mem, ex_use2, ex_rs2))     o_fwd_b = 2'b01;
         else if (hit(i_rd_wren_wb, rd_wb, ex_use2, ex_rs2))  o_fwd_b = 2'b10;
      end
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state         <= ST_RUN;
         wait_cnt      <= '0;
         o_mem_timeout <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (i_mem_req && !i_mem_ack) begin
                  state    <= ST_WAIT;
                  wait_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (i_mem_ack) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else begin
                  if (!(&wait_cnt)) wait_cnt <= wait_inc[WAIT_W-1:0];
                  if (MEM_TIMEOUT != 0 && wait_inc >= TMO) begin
                     state         <= ST_TOUT;
                     o_mem_timeout <= 1'b1;
                  end
               end
            end
            ST_TOUT: ;
            default: state <= ST_RUN;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (!o_en_pc && !(&o_stall_cnt))   o_stall_cnt <= o_stall_cnt + CNT_W'(1);
         if (o_flush_if && !(&o_flush_cnt)) o_flush_cnt <= o_flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hdu_fwd.sv
// Bench for hdu_fwd: a forwarding/timeout instance and a no-forwarding narrow-counter
// instance share stimulus; a spec-level model checks both every cycle.
module tb_hdu_fwd;

   typedef struct packed {
      logic       en_pc, en_if, en_id, en_ex, en_mem, fl_if, fl_id;
      logic [1:0] fa, fb;
   } out_t;

   typedef struct {
      string       name;
      logic [31:0] id, ex, mem, wb;
      logic        wex, wmem, wwb, rden, pcsel;
      out_t        exp_a;
      logic [2:0]  exp_b;   // {en_pc, flush_if, flush_id}
   } vec_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] id, ex, mem, wb;
   logic        wex, wmem, wwb, rden, pcsel, req, ack;

   logic        a_en_pc, a_en_if, a_en_id, a_en_ex, a_en_mem, a_fl_if, a_fl_id, a_tout;
   logic [1:0]  a_fa, a_fb;
   logic [31:0] a_stall, a_flush;
   logic        b_en_pc, b_en_if, b_en_id, b_en_ex, b_en_mem, b_fl_if, b_fl_id, b_tout;
   logic [1:0]  b_fa, b_fb;
   logic [1:0]  b_stall, b_flush;
   out_t        a_out, b_out;

   assign a_out = {a_en_pc, a_en_if, a_en_id, a_en_ex, a_en_mem, a_fl_if, a_fl_id, a_fa, a_fb};
   assign b_out = {b_en_pc, b_en_if, b_en_id, b_en_ex, b_en_mem, b_fl_if, b_fl_id, b_fa, b_fb};

   hdu_fwd #(.FWD_EN(1), .RF_WT(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut_a (
      .i_clk(clk), .i_reset(rst),
      .i_instr_id(id), .i_instr_ex(ex), .i_instr_mem(mem), .i_instr_wb(wb),
      .i_rd_wren_ex(wex), .i_rd_wren_mem(wmem), .i_rd_wren_wb(wwb),
      .i_mem_rden_ex(rden), .i_pc_sel_ex(pcsel), .i_mem_req(req), .i_mem_ack(ack),
      .o_en_pc(a_en_pc), .o_en_if(a_en_if), .o_en_id(a_en_id), .o_en_ex(a_en_ex),
      .o_en_mem(a_en_mem), .o_flush_if(a_fl_if), .o_flush_id(a_fl_id),
      .o_fwd_a(a_fa), .o_fwd_b(a_fb), .o_stall_cnt(a_stall), .o_flush_cnt(a_flush),
      .o_mem_timeout(a_tout));

   hdu_fwd #(.FWD_EN(0), .RF_WT(0), .MEM_TIMEOUT(0), .CNT_W(2)) dut_b (
      .i_clk(clk), .i_reset(rst),
      .i_instr_id(id), .i_instr_ex(ex), .i_instr_mem(mem), .i_instr_wb(wb),
      .i_rd_wren_ex(wex), .i_rd_wren_mem(wmem), .i_rd_wren_wb(wwb),
      .i_mem_rden_ex(rden), .i_pc_sel_ex(pcsel), .i_mem_req(req), .i_mem_ack(ack),
      .o_en_pc(b_en_pc), .o_en_if(b_en_if), .o_en_id(b_en_id), .o_en_ex(b_en_ex),
      .o_en_mem(b_en_mem), .o_flush_if(b_fl_if), .o_flush_id(b_fl_id),
      .o_fwd_a(b_fa), .o_fwd_b(b_fb), .o_stall_cnt(b_stall), .o_flush_cnt(b_flush),
      .o_mem_timeout(b_tout));

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 running, 1 waiting for ack, 2 timed out (dead until reset)
   int     mode[2];
   int     waited[2];
   longint stalls[2];
   longint flushes[2];
   bit     tflag[2];

   function automatic bit     cfg_fwd(int k);  return k == 0; endfunction
   function automatic bit     cfg_rfwt(int k); return k == 0; endfunction
   function automatic int     cfg_tmo(int k);  return (k == 0) ? 4 : 0; endfunction
   function automatic longint cfg_max(int k);  return (k == 0) ? 64'hFFFF_FFFF : 64'd3; endfunction

   function automatic bit rs1_used(logic [31:0] ins);
      return !(ins[6:0] == 7'h37 || ins[6:0] == 7'h17 || ins[6:0] == 7'h6f);
   endfunction
   function automatic bit rs2_used(logic [31:0] ins);
      return ins[6:0] == 7'h33 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63;
   endfunction
   function automatic bit reads(logic [31:0] ins, logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      return (rs1_used(ins) && ins[19:15] == r) || (rs2_used(ins) && ins[24:20] == r);
   endfunction
   function automatic logic [1:0] pick(bit used, logic [4:0] s, logic [4:0] pm, logic [4:0] pw);
      if (!used || s == 5'd0) return 2'd0;
      if (s == pm) return 2'd1;
      if (s == pw) return 2'd2;
      return 2'd0;
   endfunction

   function automatic out_t m_expect(int k);
      out_t       o;
      bit         frozen, haz;
      logic [4:0] p_ex, p_mem, p_wb;
      o = '{en_pc: 1, en_if: 1, en_id: 1, en_ex: 1, en_mem: 1, fl_if: 0, fl_id: 0, fa: 0, fb: 0};
      if (rst) return o;
      p_ex  = wex  ? ex[11:7]  : 5'd0;
      p_mem = wmem ? mem[11:7] : 5'd0;
      p_wb  = wwb  ? wb[11:7]  : 5'd0;
      if (cfg_fwd(k))
         haz = (rden && reads(id, p_ex)) || (!cfg_rfwt(k) && reads(id, p_wb));
      else
         haz = reads(id, p_ex) || reads(id, p_mem) || (!cfg_rfwt(k) && reads(id, p_wb));
      frozen = (mode[k] == 2) || (mode[k] == 1 ? !ack : (req && !ack));
      if (frozen) begin
         o.en_pc = 0; o.en_if = 0; o.en_id = 0; o.en_ex = 0; o.en_mem = 0;
      end else if (pcsel) begin
         o.fl_if = 1; o.fl_id = 1;
      end else if (haz) begin
         o.en_pc = 0; o.en_if = 0; o.fl_id = 1;
      end
      if (cfg_fwd(k)) begin
         o.fa = pick(rs1_used(ex), ex[19:15], p_mem, p_wb);
         o.fb = pick(rs2_used(ex), ex[24:20], p_mem, p_wb);
      end
      return o;
   endfunction

   task automatic m_clear(int k);
      mode[k] = 0; waited[k] = 0; stalls[k] = 0; flushes[k] = 0; tflag[k] = 0;
   endtask

   task automatic m_update(int k, out_t e);
      if (!e.en_pc && stalls[k] < cfg_max(k))  stalls[k]++;
      if (e.fl_if && flushes[k] < cfg_max(k)) flushes[k]++;
      case (mode[k])
         0: if (req && !ack) begin mode[k] = 1; waited[k] = 0; end
         1: begin
            if (ack) begin
               mode[k] = 0; waited[k] = 0;
            end else begin
               waited[k]++;
               if (cfg_tmo(k) > 0 && waited[k] >= cfg_tmo(k)) begin mode[k] = 2; tflag[k] = 1; end
            end
         end
         default: ;
      endcase
   endtask

   // Sample #1 after the negedge on which inputs were driven.
   task automatic settle();
      #1;
      if (rst) begin m_clear(0); m_clear(1); end
      check("a.outputs", 32'(a_out), 32'(m_expect(0)));
      check("b.outputs", 32'(b_out), 32'(m_expect(1)));
      check("a.stall_cnt", a_stall, 32'(stalls[0]));
      check("a.flush_cnt", a_flush, 32'(flushes[0]));
      check("a.timeout", 32'(a_tout), 32'(tflag[0]));
      check("b.stall_cnt", 32'(b_stall), 32'(stalls[1]));
      check("b.flush_cnt", 32'(b_flush), 32'(flushes[1]));
      check("b.timeout", 32'(b_tout), 32'(tflag[1]));
   endtask

   task automatic tick();
      out_t e0, e1;
      e0 = m_expect(0);
      e1 = m_expect(1);
      @(posedge clk);
      if (!rst) begin m_update(0, e0); m_update(1, e1); end
      @(negedge clk);
   endtask

   task automatic set_idle();
      id = NOP; ex = NOP; mem = NOP; wb = NOP;
      wex = 0; wmem = 0; wwb = 0; rden = 0; pcsel = 0; req = 0; ack = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_idle();
      @(negedge clk);
      settle();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] e_r(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
   endfunction
   function automatic logic [31:0] e_ld(logic [4:0] rd, logic [4:0] rs1);
      return {12'd0, rs1, 3'd2, rd, 7'h03};
   endfunction
   function automatic logic [31:0] e_addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
      return {imm, rs1, 3'd0, rd, 7'h13};
   endfunction
   function automatic logic [31:0] e_sw(logic [4:0] rs2, logic [4:0] rs1);
      return {7'd0, rs2, rs1, 3'd2, 5'd0, 7'h23};
   endfunction
   function automatic logic [31:0] e_beq(logic [4:0] rs1, logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, 5'd0, 7'h63};
   endfunction
   function automatic logic [31:0] e_lui(logic [4:0] rd, logic [19:0] imm);
      return {imm, rd, 7'h37};
   endfunction
   function automatic logic [31:0] e_jal(logic [4:0] rd, logic [19:0] imm);
      return {imm, rd, 7'h6f};
   endfunction

   function automatic out_t mk(bit en, bit fi, bit fd, logic [1:0] fa, logic [1:0] fb);
      return '{en_pc: en, en_if: en, en_id: 1, en_ex: 1, en_mem: 1, fl_if: fi, fl_id: fd, fa: fa, fb: fb};
   endfunction

   vec_t tbl[$];

   task automatic add_vec(string n, logic [31:0] i_id, logic [31:0] i_ex, logic [31:0] i_mem,
                          logic [31:0] i_wb, logic [4:0] flags, out_t ea, logic [2:0] eb);
      vec_t v;
      v.name = n; v.id = i_id; v.ex = i_ex; v.mem = i_mem; v.wb = i_wb;
      {v.wex, v.wmem, v.wwb, v.rden, v.pcsel} = flags;
      v.exp_a = ea; v.exp_b = eb;
      tbl.push_back(v);
   endtask

   logic [6:0] ops[8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      ins        = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 7)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      return ins;
   endfunction

   initial begin
      // flags = {wex, wmem, wwb, rden, pcsel}
      add_vec("all_bubbles", NOP, NOP, NOP, NOP, 5'b00000, mk(1,0,0,0,0), 3'b100);
      add_vec("alu_ex_dep", e_r(6,5,3), e_r(5,1,2), NOP, NOP, 5'b10000, mk(1,0,0,0,0), 3'b001);
      add_vec("load_use", e_r(6,5,5), e_ld(5,1), NOP, NOP, 5'b10010, mk(0,0,1,0,0), 3'b001);
      add_vec("load_use_br", e_r(6,5,5), e_ld(5,1), NOP, NOP, 5'b10011, mk(1,1,1,0,0), 3'b111);
      add_vec("fwd_mem_wb", NOP, e_r(6,5,7), e_r(5,1,2), e_addi(7,0,1), 5'b11100, mk(1,0,0,1,2), 3'b100);
      add_vec("fwd_mem_wins", NOP, e_r(6,5,5), e_r(5,1,2), e_r(5,2,3), 5'b11100, mk(1,0,0,1,1), 3'b100);
      add_vec("wb_dep", e_r(8,7,0), NOP, NOP, e_addi(7,0,1), 5'b00100, mk(1,0,0,0,0), 3'b001);
      add_vec("lui_no_rs1", e_lui(7,20'h00038), e_ld(7,1), NOP, NOP, 5'b10010, mk(1,0,0,0,0), 3'b100);
      add_vec("rd_x0", e_r(6,0,0), e_ld(0,1), NOP, NOP, 5'b10010, mk(1,0,0,0,0), 3'b100);
      add_vec("store_rs2", e_sw(5,1), e_ld(5,1), NOP, NOP, 5'b10010, mk(0,0,1,0,0), 3'b001);
      add_vec("itype_no_rs2", e_addi(6,1,12'd5), e_ld(5,1), NOP, NOP, 5'b10010, mk(1,0,0,0,0), 3'b100);
      add_vec("jal_no_rs1", e_jal(1,20'h00028), e_ld(5,1), NOP, NOP, 5'b10010, mk(1,0,0,0,0), 3'b100);
      add_vec("mem_dep", e_r(6,5,0), NOP, e_r(5,1,2), NOP, 5'b01000, mk(1,0,0,0,0), 3'b001);
      add_vec("branch_rs2", e_beq(1,5), e_ld(5,1), NOP, NOP, 5'b10010, mk(0,0,1,0,0), 3'b001);
      add_vec("ex_lui_nofwd", NOP, e_lui(6,20'h00038), NOP, e_addi(7,0,1), 5'b10100, mk(1,0,0,0,0), 3'b100);

      do_reset();

      foreach (tbl[i]) begin
         set_idle();
         id = tbl[i].id; ex = tbl[i].ex; mem = tbl[i].mem; wb = tbl[i].wb;
         wex = tbl[i].wex; wmem = tbl[i].wmem; wwb = tbl[i].wwb;
         rden = tbl[i].rden; pcsel = tbl[i].pcsel;
         settle();
         check({tbl[i].name, ".a"}, 32'(a_out), 32'(tbl[i].exp_a));
         check({tbl[i].name, ".b"}, 32'({b_en_pc, b_fl_if, b_fl_id}), 32'(tbl[i].exp_b));
         check({tbl[i].name, ".b_fwd"}, 32'({b_fa, b_fb}), 32'd0);
         tick();
      end

      // Load-use: one stall cycle, then WB forwarding to both operands.
      do_reset();
      id = e_r(6,5,5); ex = e_ld(5,1); wex = 1; rden = 1;
      settle();
      check("lu.en_pc", 32'(a_en_pc), 0);
      check("lu.en_if", 32'(a_en_if), 0);
      check("lu.flush_id", 32'(a_fl_id), 1);
      tick();
      ex = NOP; wex = 0; rden = 0; mem = e_ld(5,1); wmem = 1;
      settle();
      check("lu.resume", 32'(a_en_pc), 1);
      tick();
      id = NOP; ex = e_r(6,5,5); wex = 1; mem = NOP; wmem = 0; wb = e_ld(5,1); wwb = 1;
      settle();
      check("lu.fwd_a", 32'(a_fa), 2);
      check("lu.fwd_b", 32'(a_fb), 2);
      check("lu.stall_cnt", a_stall, 1);
      tick();

      // Load-use coinciding with a taken branch: control wins, nothing counted as stall.
      do_reset();
      id = e_r(6,5,5); ex = e_ld(5,1); wex = 1; rden = 1; pcsel = 1;
      settle();
      check("lubr.flushes", 32'({a_en_pc, a_fl_if, a_fl_id}), 32'b111);
      tick();
      set_idle();
      settle();
      check("lubr.stall_cnt", a_stall, 0);
      check("lubr.flush_cnt", a_flush, 1);

      // Memory wait of 3 cycles with a branch arriving mid-freeze.
      do_reset();
      req = 1;
      settle();
      check("mw.c0_frozen", 32'({a_en_pc, a_en_mem}), 0);
      tick();
      pcsel = 1;
      settle();
      check("mw.c1_frozen", 32'({a_en_pc, a_fl_if}), 0);
      tick();
      settle();
      check("mw.c2_frozen", 32'(a_en_ex), 0);
      tick();
      ack = 1;
      settle();
      check("mw.ack_cycle", 32'({a_en_pc, a_en_mem, a_fl_if}), 32'b111);
      tick();
      set_idle();
      settle();
      check("mw.stall_cnt", a_stall, 3);
      check("mw.flush_cnt", a_flush, 1);

      // Timeout: request held without ack.
      do_reset();
      req = 1;
      repeat (4) begin settle(); tick(); end
      settle();
      check("to.not_yet", 32'(a_tout), 0);
      tick();
      req = 0; ack = 1;
      settle();
      check("to.flag", 32'(a_tout), 1);
      check("to.frozen", 32'(a_en_pc), 0);
      tick();
      settle();
      check("to.persist", 32'(a_en_pc), 0);
      do_reset();
      settle();
      check("to.cleared", 32'({a_tout, a_en_pc}), 32'b01);
      check("to.cnt_cleared", a_stall, 0);
      tick();

      // No-forwarding instance: WB producer stalls exactly one cycle.
      do_reset();
      wb = e_addi(7,0,1); wwb = 1; id = e_r(8,7,0);
      settle();
      check("nf.wb_stall", 32'({b_en_pc, b_fl_id}), 32'b01);
      check("nf.fwd_inst_ok", 32'(a_en_pc), 1);
      tick();
      wb = NOP; wwb = 0;
      settle();
      check("nf.released", 32'(b_en_pc), 1);
      tick();

      // Randomized traffic against the model, with occasional resets.
      for (int n = 0; n < 800; n++) begin
         rst   = ($urandom_range(0, 59) == 0);
         id    = rand_instr();
         ex    = rand_instr();
         mem   = rand_instr();
         wb    = rand_instr();
         wex   = 1'($urandom_range(0, 1));
         wmem  = 1'($urandom_range(0, 1));
         wwb   = 1'($urandom_range(0, 1));
         rden  = 1'($urandom_range(0, 1));
         pcsel = ($urandom_range(0, 5) == 0);
         req   = ($urandom_range(0, 3) == 0);
         ack   = 1'($urandom_range(0, 1));
         settle();
         tick();
      end
      rst = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
